router_fsm: RTL and testbench

- Control block for the 1x3 router.
- Decodes each incoming packet's destination from the header byte and sequences writes into the three output FIFOs, stalling on full and waiting on a busy destination.
- Runs per-port read-timeout counters that issue soft_reset to a FIFO whose data is not consumed in time.
- Sits between the input interface and the register/data block; drives write_enb and lfd_state to the FIFOs.

---
 rtl/router_fsm.sv | 112 +++++++++++
 tb/tb_router_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: header decode, FIFO write sequencing and
// per-port read-timeout soft resets.
module router_fsm #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic       detect_add,
    output logic [2:0] valid_out,
    output logic [2:0] soft_reset
);

    typedef enum logic [2:0] {
        StDecodeAddress,
        StWaitTillEmpty,
        StLoadFirstData,
        StLoadData,
        StFifoFullState,
        StLoadAfterFull,
        StLoadParity,
        StCheckParityError
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];

    assign valid_out = ~fifo_empty;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        // A timeout on the port being written abandons the packet.
        if (state_q != StDecodeAddress && soft_reset[addr_q]) begin
            state_d = StDecodeAddress;
        end else begin
            unique case (state_q)
                StDecodeAddress: begin
                    if (pkt_valid && data_in[1:0] != 2'd3) begin
                        addr_d  = data_in[1:0];
                        state_d = fifo_empty[data_in[1:0]] ? StLoadFirstData : StWaitTillEmpty;
                    end
                end
                StWaitTillEmpty: begin
                    if (fifo_empty[addr_q]) state_d = StLoadFirstData;
                end
                StLoadFirstData: state_d = StLoadData;
                StLoadData: begin
                    if (fifo_full[addr_q])  state_d = StFifoFullState;
                    else if (!pkt_valid)    state_d = StLoadParity;
                end
                StFifoFullState: begin
                    if (!fifo_full[addr_q]) state_d = StLoadAfterFull;
                end
                StLoadAfterFull: state_d = pkt_valid ? StLoadData : StLoadParity;
                StLoadParity:       state_d = StCheckParityError;
                StCheckParityError: state_d = StDecodeAddress;
                default:            state_d = StDecodeAddress;
            endcase
        end
    end

    // Outputs are registered from the next state so they are glitch-free Moore outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StDecodeAddress;
            addr_q     <= 2'd0;
            write_enb  <= 3'b000;
            lfd_state  <= 1'b0;
            busy       <= 1'b0;
            detect_add <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_enb  <= (state_d == StLoadData || state_d == StLoadAfterFull ||
                           state_d == StLoadParity) ? (3'b001 << addr_d) : 3'b000;
            lfd_state  <= (state_d == StLoadFirstData);
            busy       <= !(state_d == StDecodeAddress || state_d == StLoadData);
            detect_add <= (state_d == StDecodeAddress);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    cnt_q[i]      <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                    cnt_q[i]      <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt_q[i]      <= cnt_q[i] + 1'b1;
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: vector table, directed timeout/abort
// sequences and a randomized run against a packet-level reference model.
module tb_router_fsm;

    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic [2:0] write_enb, valid_out, soft_reset;
    logic       lfd_state, busy, detect_add;

    int n_checks = 0;
    int n_pass   = 0;

    router_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .busy       (busy),
        .detect_add (detect_add),
        .valid_out  (valid_out),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [7:0] din;
        logic [2:0] full, empty, rd;
        logic [2:0] we;
        logic       lfd, bsy, det;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic pv, logic [7:0] din, logic [2:0] full,
                                logic [2:0] empty, logic [2:0] rd, logic [2:0] we,
                                logic lfd, logic bsy, logic det);
        vec_t v;
        v.rst = rst; v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.rd = rd;
        v.we = we; v.lfd = lfd; v.bsy = bsy; v.det = det;
        tbl.push_back(v);
    endfunction

    function automatic logic [8:0] outs();
        return {write_enb, lfd_state, busy, detect_add, soft_reset};
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %03h, expected %03h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic rst, logic pv, logic [7:0] din, logic [2:0] full,
                         logic [2:0] empty, logic [2:0] rd);
        resetn = rst; pkt_valid = pv; data_in = din;
        fifo_full = full; fifo_empty = empty; read_enb = rd;
    endtask

    // Reference model: packet phase by name, run length of unread cycles per port.
    string      m_ph;
    logic [1:0] m_addr;
    int         m_run [3];
    logic [2:0] m_sr;

    task automatic model_step();
        string nx;
        if (!resetn) begin
            m_ph = "DA"; m_addr = 2'd0; m_sr = 3'b000;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            return;
        end
        nx = m_ph;
        if (m_ph != "DA" && m_sr[m_addr]) nx = "DA";
        else if (m_ph == "DA") begin
            if (pkt_valid && data_in[1:0] != 2'd3) begin
                m_addr = data_in[1:0];
                nx = fifo_empty[m_addr] ? "LFD" : "WTE";
            end
        end
        else if (m_ph == "WTE") begin if (fifo_empty[m_addr]) nx = "LFD"; end
        else if (m_ph == "LFD") nx = "LD";
        else if (m_ph == "LD") begin
            if (fifo_full[m_addr]) nx = "FFS";
            else if (!pkt_valid)   nx = "LP";
        end
        else if (m_ph == "FFS") begin if (!fifo_full[m_addr]) nx = "LAF"; end
        else if (m_ph == "LAF") nx = pkt_valid ? "LD" : "LP";
        else if (m_ph == "LP")  nx = "CPE";
        else                    nx = "DA";
        m_ph = nx;
        for (int i = 0; i < 3; i++) begin
            if (fifo_empty[i] || read_enb[i]) begin
                m_run[i] = 0; m_sr[i] = 1'b0;
            end else begin
                m_run[i]++;
                m_sr[i] = (m_run[i] % TIMEOUT == 0);
            end
        end
    endtask

    function automatic logic [8:0] model_outs();
        logic [2:0] we;
        we = (m_ph == "LD" || m_ph == "LAF" || m_ph == "LP") ? (3'b001 << m_addr) : 3'b000;
        return {we, m_ph == "LFD", !(m_ph == "DA" || m_ph == "LD"), m_ph == "DA", m_sr};
    endfunction

    initial begin
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);

        // Vector table: each row's outputs are expected after the edge that samples its inputs.
        add(0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 1);
        add(1, 1, 8'h39, 3'b000, 3'b111, 3'b000, 3'b000, 1, 1, 0);
        for (int k = 0; k < 14; k++)
            add(1, 1, 8'(k + 16), 3'b000, 3'b111, 3'b000, 3'b010, 0, 0, 0);
        add(1, 0, 8'h5a, 3'b000, 3'b111, 3'b000, 3'b010, 0, 1, 0);
        add(1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 3'b000, 0, 1, 0);
        add(1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 1);
        add(1, 1, 8'h03, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            add(1, 1, 8'h02, 3'b000, 3'b011, 3'b000, 3'b000, 0, 1, 0);
        add(1, 1, 8'h02, 3'b000, 3'b111, 3'b000, 3'b000, 1, 1, 0);
        add(1, 1, 8'h11, 3'b000, 3'b111, 3'b000, 3'b100, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(1, 1, 8'h12, 3'b100, 3'b111, 3'b000, 3'b000, 0, 1, 0);
        add(1, 1, 8'h13, 3'b000, 3'b111, 3'b000, 3'b100, 0, 1, 0);
        add(1, 1, 8'h14, 3'b000, 3'b111, 3'b000, 3'b100, 0, 0, 0);
        add(1, 0, 8'h15, 3'b100, 3'b111, 3'b000, 3'b000, 0, 1, 0);
        add(1, 0, 8'h15, 3'b000, 3'b111, 3'b000, 3'b100, 0, 1, 0);
        add(1, 0, 8'h15, 3'b000, 3'b111, 3'b000, 3'b100, 0, 1, 0);
        add(1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 3'b000, 0, 1, 0);
        add(1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].pv, tbl[i].din, tbl[i].full, tbl[i].empty, tbl[i].rd);
            step();
            check($sformatf("vec%0d", i), {3'b000, outs()},
                  {3'b000, tbl[i].we, tbl[i].lfd, tbl[i].bsy, tbl[i].det, 3'b000});
            check($sformatf("vec%0d_valid_out", i), {9'd0, valid_out}, {9'd0, ~tbl[i].empty});
        end

        // Timeout on port 0: pulses at 30 and 60 unread cycles.
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
        step();
        drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
        for (int i = 1; i <= 60; i++) begin
            step();
            check($sformatf("timeout_run%0d", i), {9'd0, soft_reset},
                  {9'd0, (i == 30 || i == 60) ? 3'b001 : 3'b000});
        end
        // A read on cycle 29 restarts the count.
        for (int i = 1; i <= 29; i++) begin
            read_enb = (i == 29) ? 3'b001 : 3'b000;
            step();
            check($sformatf("timeout_read%0d", i), {9'd0, soft_reset}, 12'd0);
        end
        read_enb = 3'b000;
        for (int i = 1; i <= 30; i++) begin
            step();
            check($sformatf("timeout_restart%0d", i), {9'd0, soft_reset},
                  {9'd0, (i == 30) ? 3'b001 : 3'b000});
        end

        // Timeout on the port being written aborts the packet.
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
        step();
        drive(1'b1, 1'b1, 8'h00, 3'b000, 3'b111, 3'b000);
        step();
        drive(1'b1, 1'b1, 8'h03, 3'b000, 3'b110, 3'b000);
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 30) check("abort_pulse", {3'b000, outs()}, {3'b000, 3'b001, 3'b000, 3'b001});
            if (i == 31) check("abort_da", {3'b000, outs()}, {3'b000, 3'b000, 3'b001, 3'b000});
        end

        // Reset mid-packet clears the FSM and the timeout counters.
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
        step();
        drive(1'b1, 1'b1, 8'h01, 3'b000, 3'b111, 3'b000);
        step();
        drive(1'b1, 1'b1, 8'h03, 3'b000, 3'b110, 3'b000);
        for (int i = 0; i < 20; i++) step();
        check("pre_reset_ld", {3'b000, outs()}, {3'b000, 3'b010, 3'b000, 3'b000});
        resetn = 1'b0;
        step();
        check("reset_mid_ld", {3'b000, outs()}, {3'b000, 3'b000, 3'b001, 3'b000});
        drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
        for (int i = 1; i <= 30; i++) begin
            step();
            check($sformatf("post_reset_timeout%0d", i), {9'd0, soft_reset},
                  {9'd0, (i == 30) ? 3'b001 : 3'b000});
        end

        // Randomized run against the reference model.
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
        step();
        model_step();
        check("rand_reset", {3'b000, outs()}, {3'b000, model_outs()});
        for (int c = 0; c < 4000; c++) begin
            resetn    = ($urandom_range(0, 499) != 0);
            pkt_valid = ($urandom_range(0, 9) != 0);
            data_in   = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                fifo_full[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 19) == 0) fifo_empty[i] = ~fifo_empty[i];
                read_enb[i] = ($urandom_range(0, 39) == 0);
            end
            step();
            model_step();
            check($sformatf("rand%0d", c), {3'b000, outs()}, {3'b000, model_outs()});
            check($sformatf("rand%0d_valid_out", c), {9'd0, valid_out}, {9'd0, ~fifo_empty});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
